// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: next-PC selector codes, the nop word,
// the reset vector and the fetch FSM state type.
package mips_pkg;

    localparam logic [1:0]  NPC_SEQ          = 2'b00;
    localparam logic [1:0]  NPC_BR           = 2'b01;
    localparam logic [1:0]  NPC_JR           = 2'b10;
    localparam logic [1:0]  NPC_J            = 2'b11;

    localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_stage_npc_calc.sv
// npc_calc: combinational redirect target for branch, register jump and jump,
// computed from the instruction currently in ID and its PC+4.
module npc_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        i_npcOp,
    input  logic [ADDR_W-1:0] i_pc4,
    input  logic [25:0]       i_instrIndex,
    input  logic [31:0]       i_rsValue,
    output logic [ADDR_W-1:0] o_target
);

    logic [31:0]       w_rsAligned;
    logic [ADDR_W-1:0] w_brOffset;

    // jr/jalr targets are word aligned regardless of the low bits of rs
    assign w_rsAligned = i_rsValue & 32'hFFFF_FFFC;
    assign w_brOffset  = {{(ADDR_W-18){i_instrIndex[15]}}, i_instrIndex[15:0], 2'b00};

    always_comb begin
        o_target = i_pc4;
        case (i_npcOp)
            NPC_BR:  o_target = i_pc4 + w_brOffset;
            NPC_JR:  o_target = w_rsAligned[ADDR_W-1:0];
            NPC_J:   o_target = {i_pc4[ADDR_W-1:28], i_instrIndex, 2'b00};
            default: o_target = i_pc4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, fetch FSM, hold buffer, pending delay-slot redirect and IF/ID register.
// Optional macro IF_PERF_EN adds saturating bubble and redirect counters.
module if_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        ID_npcOp,
    input  logic              ID_nostall,
    input  logic [31:0]       ID_rs_value,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       ID_instr,
    output logic [ADDR_W-1:0] ID_pc4,
    output logic              ID_valid
`ifdef IF_PERF_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_redirects
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_holdPc4;
    logic [ADDR_W-1:0] r_pendTarget;
    logic [ADDR_W-1:0] r_idPc4;
    logic [31:0]       r_holdInstr;
    logic [31:0]       r_idInstr;
    logic              r_pendValid;
    logic              r_idValid;

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_fetchPc4;
    logic [31:0]       w_word;
    logic              w_reqState;
    logic              w_avail;
    logic              w_accept;
    logic              w_redirect;
    logic              w_capture;

    assign w_pc4      = r_pc + ADDR_W'(4);
    assign w_accept   = w_avail & ID_nostall;
    assign w_redirect = r_idValid & ID_nostall & (ID_npcOp != NPC_SEQ);
    assign w_capture  = (r_state == FETCH) & imem_ready & ~ID_nostall;

    assign imem_req   = w_reqState & rstn;
    assign imem_addr  = r_pc;
    assign ID_instr   = r_idInstr;
    assign ID_pc4     = r_idPc4;
    assign ID_valid   = r_idValid;

    npc_calc #(
        .ADDR_W (ADDR_W)
    ) u_npcCalc (
        .i_npcOp      (ID_npcOp),
        .i_pc4        (r_idPc4),
        .i_instrIndex (r_idInstr[25:0]),
        .i_rsValue    (ID_rs_value),
        .o_target     (w_target)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= FETCH;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (w_accept)       w_nextState = FETCH;
        else if (w_capture) w_nextState = HOLD;
    end

    // In HOLD the word and its PC+4 come from the buffer captured during the stall
    always_comb begin
        w_reqState = 1'b0;
        w_avail    = 1'b1;
        w_word     = r_holdInstr;
        w_fetchPc4 = r_holdPc4;
        if (r_state == FETCH) begin
            w_reqState = 1'b1;
            w_avail    = imem_ready;
            w_word     = imem_rdata;
            w_fetchPc4 = w_pc4;
        end
    end

    // A redirect seen before the delay slot is fetched is parked until that fetch is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc         <= RESET_PC;
            r_pendValid  <= 1'b0;
            r_pendTarget <= '0;
        end else if (w_accept) begin
            r_pendValid <= 1'b0;
            if (w_redirect)       r_pc <= w_target;
            else if (r_pendValid) r_pc <= r_pendTarget;
            else                  r_pc <= w_pc4;
        end else if (w_redirect) begin
            r_pendValid  <= 1'b1;
            r_pendTarget <= w_target;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_holdInstr <= MIPS_NOP;
            r_holdPc4   <= '0;
        end else if (w_capture) begin
            r_holdInstr <= imem_rdata;
            r_holdPc4   <= w_pc4;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idInstr <= MIPS_NOP;
            r_idPc4   <= '0;
            r_idValid <= 1'b0;
        end else if (ID_nostall) begin
            if (w_avail) begin
                r_idInstr <= w_word;
                r_idPc4   <= w_fetchPc4;
                r_idValid <= 1'b1;
            end else begin
                r_idInstr <= MIPS_NOP;
                r_idValid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] r_perfBubbles;
    logic [31:0] r_perfRedirects;
    logic        w_bubble;

    assign w_bubble       = ID_nostall & ~w_avail;
    assign perf_bubbles   = r_perfBubbles;
    assign perf_redirects = r_perfRedirects;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perfBubbles   <= '0;
            r_perfRedirects <= '0;
        end else begin
            if (w_bubble && (r_perfBubbles != 32'hFFFF_FFFF))
                r_perfBubbles <= r_perfBubbles + 32'd1;
            if (w_redirect && (r_perfRedirects != 32'hFFFF_FFFF))
                r_perfRedirects <= r_perfRedirects + 32'd1;
        end
    end
`endif

    // The delay slot must reach ID before a second redirect can be issued
    redirectNotPending: assert property (@(posedge clk) disable iff (!rstn)
        !(w_redirect && r_pendValid));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, branch/jump delay slot,
// stalls with a ready imem, slow imem with jr, load-use gating and reset mid-fetch.
module tb_if_stage;

    logic        clk;
    logic        rstn;
    logic [1:0]  ID_npcOp;
    logic        ID_nostall;
    logic [31:0] ID_rs_value;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] ID_instr;
    logic [31:0] ID_pc4;
    logic        ID_valid;
`ifdef IF_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_redirects;
`endif

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk         (clk),
        .rstn        (rstn),
        .ID_npcOp    (ID_npcOp),
        .ID_nostall  (ID_nostall),
        .ID_rs_value (ID_rs_value),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .ID_instr    (ID_instr),
        .ID_pc4      (ID_pc4),
        .ID_valid    (ID_valid)
`ifdef IF_PERF_EN
        ,
        .perf_bubbles   (perf_bubbles),
        .perf_redirects (perf_redirects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: beq +4 at 0x3000, otherwise a word tagged with its address
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0000_3000) return 32'h1000_0004;
        return {16'h2000, addr[15:0]};
    endfunction

    always_comb imem_rdata = memWord(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstn        = 1'b0;
        ID_npcOp    = 2'b00;
        ID_nostall  = 1'b1;
        ID_rs_value = 32'h0;
        imem_ready  = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        ID_npcOp    = 2'b00;
        ID_nostall  = 1'b1;
        ID_rs_value = 32'h0;
        imem_ready  = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b expected 0", imem_req); end
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b expected 0", ID_valid); end
        checks++; if (ID_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %h expected 0", ID_instr); end
        checks++; if (ID_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc4 got %h expected 0", ID_pc4); end
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL rst_addr got %h expected 3000", imem_addr); end
        rstn = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_req0 got %b expected 1", imem_req); end
        tick();
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL seq_addr1 got %h expected 3004", imem_addr); end
        checks++; if (ID_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid1 got %b expected 1", ID_valid); end
        checks++; if (ID_pc4 !== 32'h3004) begin errors++; $display("[TB] FAIL seq_pc4_1 got %h expected 3004", ID_pc4); end
        checks++; if (ID_instr !== 32'h1000_0004) begin errors++; $display("[TB] FAIL seq_instr1 got %h expected 10000004", ID_instr); end
        tick();
        checks++; if (imem_addr !== 32'h3008) begin errors++; $display("[TB] FAIL seq_addr2 got %h expected 3008", imem_addr); end
        checks++; if (ID_pc4 !== 32'h3008) begin errors++; $display("[TB] FAIL seq_pc4_2 got %h expected 3008", ID_pc4); end
    endtask

    task automatic test_branch();
        doReset();
        tick();
        ID_npcOp = 2'b01;
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL br_slot_addr got %h expected 3004", imem_addr); end
        tick();
        ID_npcOp = 2'b00;
        checks++; if (imem_addr !== 32'h3014) begin errors++; $display("[TB] FAIL br_target got %h expected 3014", imem_addr); end
        checks++; if (ID_pc4 !== 32'h3008) begin errors++; $display("[TB] FAIL br_slot_pc4 got %h expected 3008", ID_pc4); end
        tick();
        checks++; if (ID_pc4 !== 32'h3018) begin errors++; $display("[TB] FAIL br_after_pc4 got %h expected 3018", ID_pc4); end
    endtask

    task automatic test_jump();
        doReset();
        tick();
        ID_npcOp = 2'b11;
        tick();
        ID_npcOp = 2'b00;
        checks++; if (imem_addr !== 32'h0000_0010) begin errors++; $display("[TB] FAIL j_target got %h expected 00000010", imem_addr); end
    endtask

    task automatic test_stall();
        doReset();
        tick();
        ID_nostall = 1'b0;
        tick();
        imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL stall_addr got %h expected 3004", imem_addr); end
        checks++; if (ID_instr !== 32'h1000_0004) begin errors++; $display("[TB] FAIL stall_instr got %h expected 10000004", ID_instr); end
        tick();
        checks++; if (ID_pc4 !== 32'h3004) begin errors++; $display("[TB] FAIL stall_pc4 got %h expected 3004", ID_pc4); end
        tick();
        ID_nostall = 1'b1;
        tick();
        imem_ready = 1'b1;
        checks++; if (ID_instr !== 32'h2000_3004) begin errors++; $display("[TB] FAIL stall_held_instr got %h expected 20003004", ID_instr); end
        checks++; if (ID_pc4 !== 32'h3008) begin errors++; $display("[TB] FAIL stall_held_pc4 got %h expected 3008", ID_pc4); end
        checks++; if (imem_addr !== 32'h3008) begin errors++; $display("[TB] FAIL stall_next_addr got %h expected 3008", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_next_req got %b expected 1", imem_req); end
    endtask

    task automatic test_slow_jr();
        doReset();
        tick();
        ID_npcOp    = 2'b10;
        ID_rs_value = 32'h0000_4002;
        imem_ready  = 1'b0;
        tick();
        ID_npcOp = 2'b00;
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL jr_bubble_valid got %b expected 0", ID_valid); end
        checks++; if (ID_instr !== 32'h0) begin errors++; $display("[TB] FAIL jr_bubble_instr got %h expected 0", ID_instr); end
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL jr_slot_addr got %h expected 3004", imem_addr); end
        tick();
        tick();
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL jr_bubble3 got %b expected 0", ID_valid); end
        imem_ready = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h4000) begin errors++; $display("[TB] FAIL jr_target got %h expected 4000", imem_addr); end
        checks++; if (ID_pc4 !== 32'h3008) begin errors++; $display("[TB] FAIL jr_slot_pc4 got %h expected 3008", ID_pc4); end
        checks++; if (ID_valid !== 1'b1) begin errors++; $display("[TB] FAIL jr_slot_valid got %b expected 1", ID_valid); end
        tick();
        checks++; if (ID_pc4 !== 32'h4004) begin errors++; $display("[TB] FAIL jr_after_pc4 got %h expected 4004", ID_pc4); end
    endtask

    task automatic test_load_use();
        doReset();
        tick();
        ID_npcOp   = 2'b01;
        ID_nostall = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL lu_no_redirect got %h expected 3004", imem_addr); end
        checks++; if (ID_pc4 !== 32'h3004) begin errors++; $display("[TB] FAIL lu_hold_pc4 got %h expected 3004", ID_pc4); end
        ID_nostall = 1'b1;
        tick();
        ID_npcOp = 2'b00;
        checks++; if (imem_addr !== 32'h3014) begin errors++; $display("[TB] FAIL lu_target got %h expected 3014", imem_addr); end
        checks++; if (ID_pc4 !== 32'h3008) begin errors++; $display("[TB] FAIL lu_slot_pc4 got %h expected 3008", ID_pc4); end
        tick();
        checks++; if (ID_pc4 !== 32'h3018) begin errors++; $display("[TB] FAIL lu_after_pc4 got %h expected 3018", ID_pc4); end
    endtask

    task automatic test_reset_midfetch();
        doReset();
        tick();
        ID_npcOp    = 2'b10;
        ID_rs_value = 32'h0000_4002;
        imem_ready  = 1'b0;
        tick();
        ID_npcOp   = 2'b00;
        imem_ready = 1'b1;
        ID_nostall = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_hold_req got %b expected 0", imem_req); end
        rstn = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL mid_rst_addr got %h expected 3000", imem_addr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_req got %b expected 0", imem_req); end
        checks++; if (ID_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_pc4 got %h expected 0", ID_pc4); end
        ID_nostall = 1'b1;
        tick();
        rstn = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_rel_req got %b expected 1", imem_req); end
        tick();
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL mid_no_pend got %h expected 3004", imem_addr); end
        checks++; if (ID_pc4 !== 32'h3004) begin errors++; $display("[TB] FAIL mid_first_pc4 got %h expected 3004", ID_pc4); end
    endtask

    initial begin
        rstn        = 1'b0;
        ID_npcOp    = 2'b00;
        ID_nostall  = 1'b1;
        ID_rs_value = 32'h0;
        imem_ready  = 1'b1;
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_slow_jr();
        test_load_use();
        test_reset_midfetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. It sits directly upstream of the ID-stage controller. It holds the PC and issues fetches to a variable-latency instruction memory. It delivers instruction and PC+4 to ID, and applies the next-PC redirect (ID_npcOp) and load-use stall (ID_nostall) that ID computes. Branches have one architectural delay slot.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ID_npcOp  in  2  00 seq, 01 branch, 10 register jump, 11 jump
ID_nostall  in  1  0 = ID stalls; IF/ID register holds
ID_rs_value  in  32  forwarded rs value for jr/jalr target
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address (= PC)
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  fetch of imem_addr complete this cycle
ID_instr  out  32  instruction in ID (Op/Funct/rs/rt/imm sliced by ID)
ID_pc4  out  ADDR_W  PC+4 of instruction in ID
ID_valid  out  1  ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, rstn=0):
  - PC=RESET_PC, state=FETCH.
  - ID_instr=0 (nop), ID_pc4=0, ID_valid=0.
  - pend_valid=0, pend_target=0.
  - imem_req=0 while rstn=0; imem_req=1 in the first cycle after release.
- Reset mid-fetch abandons the outstanding request. Imem must ignore a dropped req.
- Redirect is qualified: redirect = ID_valid & ID_nostall & (ID_npcOp!=00).
- Target computation (npc_calc), using ID_pc4 and ID_instr:
  - 01: ID_pc4 + (sext(imm16)<<2)
  - 10: {ID_rs_value[31:2],2'b00} (low bits forced to zero)
  - 11: {ID_pc4[31:28], instr_index, 2'b00}
- FSM, state FETCH:
  - imem_req=1, imem_addr=PC.
  - avail = imem_ready.
- FSM, state HOLD:
  - imem_req=0. The fetched word is in hold_instr/hold_pc4.
  - avail=1.
- IF/ID load, when ID_nostall=1 on a clock edge:
  - if avail: ID_instr<=word (rdata or hold), ID_pc4<=fetch_pc+4, ID_valid<=1.
  - else: ID_valid<=0, ID_instr<=0 (bubble).
- IF/ID hold, when ID_nostall=0: ID_instr, ID_pc4, ID_valid keep their values.
- Fetch complete and accepted (avail & ID_nostall):
  - PC<=target if redirect this cycle; else pend_target if pend_valid (then clear pend_valid); else PC+4.
  - State goes to FETCH.
- imem_ready while ID_nostall=0: capture word into hold registers, go to HOLD, PC unchanged.
- Redirect while no fetch is accepted this cycle: latch pend_valid=1, pend_target=target. This is the delay slot still outstanding.
- Redirect while pend_valid=1 is illegal. The delay slot must pass ID first. Simulation assertion.
- Latency: single-cycle imem gives 1 instruction/cycle. First ID_valid=1 is 2 cycles after reset release.
- PC wraps modulo 2^ADDR_W; no overflow flag.

Optional Feature:
IF_PERF_EN
- Defined: adds outputs perf_bubbles[31:0] and perf_redirects[31:0], both reset to 0.
  - perf_bubbles increments on every edge that loads a bubble into ID.
  - perf_redirects increments on every qualified redirect.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_JR=2'b10, NPC_J=2'b11
  - MIPS_NOP=32'h0, RESET_PC_DEFAULT
  - fetch state enum {FETCH, HOLD}
- Sub-module npc_calc: combinational target computation from npcOp, pc4, instr, rs_value.
- if_stage holds all state: PC, FSM, hold buffer, pending redirect, IF/ID register.

Test Plan:
- Reset/sequential: release rstn, imem_ready tied 1 → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; ID_valid rises in cycle 2 with ID_pc4=0x3004.
- Branch + delay slot: beq at 0x3000 with imm16=0x0004, npcOp=01 in ID → fetch order 0x3000, 0x3004 (slot), then 0x3014.
- Stall with ready: ID_nostall=0 for 3 cycles while imem_ready=1 → imem_req drops after capture, ID_instr unchanged, PC unchanged; on release the held word enters ID and the next fetch is PC+4.
- Slow imem + jr: imem_ready delayed 3 cycles on the slot fetch while jr (rs_value=0x0000_4002) is in ID → pend_valid set, bubbles enter ID; after the slot completes the next fetch is 0x4000.
- Load-use gating: npcOp=01 with ID_nostall=0 → no redirect, no pending; redirect occurs only in the cycle ID_nostall returns to 1.
- Reset mid-fetch: rstn low while in HOLD with pend_valid=1 → all outputs at reset values; next fetch is 0x3000.
